// File: rtl/reconvolve_40mhz_pkg.sv
// -----------------------------------------------------------------------------
// reconvolve_40mhz_pkg
// Shared widths and phase constants for the ToTd reconvolver.
// The width defaults mirror the trigger-wide definitions:
//   ADC_WIDTH                       -> RECONV_ADC_WIDTH
//   COMPATIBILITY_TOTD_FD_BITS      -> RECONV_FD_BITS
//   COMPATIBILITY_TOTD_GN_BITS      -> RECONV_GN_BITS
//   COMPATIBILITY_TOTD_GN_FRAC_BITS -> RECONV_GN_FRAC_BITS
// -----------------------------------------------------------------------------
package reconvolve_40mhz_pkg;

  localparam int RECONV_ADC_WIDTH    = 12;
  localparam int RECONV_FD_BITS      = 6;
  localparam int RECONV_GN_BITS      = 8;
  localparam int RECONV_GN_FRAC_BITS = 7;

  // 40 MHz phase codes carried on ENABLE40 (3 is a pure hold phase).
  localparam logic [1:0] PHASE_STROBE = 2'd0;
  localparam logic [1:0] PHASE_PROD   = 2'd1;

endpackage : reconvolve_40mhz_pkg

// File: rtl/reconvolve_40mhz.sv
// -----------------------------------------------------------------------------
// reconvolve_40mhz
// Re-applies an exponential decay to a deconvolved 40 MHz trace:
//   x[n] = GN*y[n] + FD*x[n-1]
// running at 120 MHz with a 40 MHz phase enable (ENABLE40 == 0 is the strobe).
//
// Ports:
//   CLK       in   120 MHz clock
//   RESET     in   asynchronous active-high reset, clears all state
//   ENABLE40  in   40 MHz phase (0 strobe, 1 feedback product, 2/3 hold)
//   ADC_IN    in   deconvolved sample y[n]
//   FD        in   decay fraction .yyyyyy
//   GN        in   gain x.yyyyyyy
//   CLR_OVF   in   level clear of OVERFLOW, sampled every CLK
//   ADC_OUT   out  reconvolved sample (rounded, saturated)
//   OVERFLOW  out  sticky accumulator-saturation flag
//   DEBUG     out  only with COMPAT_TOTD_RECONV_DEBUG_EN defined:
//                  {ADC_OUT, ACC int, S6 int, IN_R}, registered every CLK
//
// Optional feature macro: COMPAT_TOTD_RECONV_DEBUG_EN
//
// Pipeline (each stage advances on the strobe only):
//   P1 IN_R <= ADC_IN
//   P2 S    <= IN_R*GN
//   P3 ACC  <= sat(S6 + PROD>>FD_BITS), PROD = ACC*FD loaded on phase 1
//   P4 ADC_OUT <= round(ACC)
// -----------------------------------------------------------------------------
module reconvolve_40mhz
  import reconvolve_40mhz_pkg::*;
#(
  parameter int ADC_WIDTH    = RECONV_ADC_WIDTH,
  parameter int FD_BITS      = RECONV_FD_BITS,
  parameter int GN_BITS      = RECONV_GN_BITS,
  parameter int GN_FRAC_BITS = RECONV_GN_FRAC_BITS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [1:0]           ENABLE40,
  input  logic [ADC_WIDTH-1:0] ADC_IN,
  input  logic [FD_BITS-1:0]   FD,
  input  logic [GN_BITS-1:0]   GN,
  input  logic                 CLR_OVF,
  output logic [ADC_WIDTH-1:0] ADC_OUT,
  output logic                 OVERFLOW
`ifdef COMPAT_TOTD_RECONV_DEBUG_EN
  ,
  output logic [4*ADC_WIDTH-1:0] DEBUG
`endif
);

  localparam int S_W    = ADC_WIDTH + GN_BITS;         // IN_R*GN
  localparam int SH     = GN_FRAC_BITS - FD_BITS;      // S -> FD_BITS fraction
  localparam int ACC_W  = ADC_WIDTH + FD_BITS;
  localparam int PROD_W = ACC_W + FD_BITS;
  // One headroom bit above the wider addend so the saturation compare is exact.
  localparam int SUM_W  = ((S_W + 1 > ACC_W) ? S_W + 1 : ACC_W) + 1;

  localparam logic [S_W:0]       S_HALF   = {{S_W{1'b0}}, 1'b1} << (SH - 1);
  localparam logic [ACC_W:0]     ACC_HALF = {{ACC_W{1'b0}}, 1'b1} << (FD_BITS - 1);
  localparam logic [ACC_W-1:0]   ACC_MAX  = '1;
  localparam logic [SUM_W-1:0]   SUM_MAX  = {{(SUM_W-ACC_W){1'b0}}, ACC_MAX};

  // Round half up to integer and clamp at full scale.
  function automatic logic [ADC_WIDTH-1:0] round_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] r;
    r = {1'b0, acc} + ACC_HALF;
    if (r[ACC_W]) begin
      return '1;
    end
    return ADC_WIDTH'(r >> FD_BITS);
  endfunction

  logic [ADC_WIDTH-1:0] in_r_q,    in_r_d;
  logic [S_W-1:0]       s_q,       s_d;
  logic [PROD_W-1:0]    prod_q,    prod_d;
  logic [ACC_W-1:0]     acc_q,     acc_d;
  logic [ADC_WIDTH-1:0] adc_out_q, adc_out_d;
  logic                 ovf_q,     ovf_d;

  logic                 strobe;
  logic                 prod_en;
  logic [S_W:0]         s_rnd;
  logic [S_W:0]         s6;
  logic [SUM_W-1:0]     sum;
  logic                 sat;
  logic                 unused_prod_frac;

  assign strobe  = (ENABLE40 == PHASE_STROBE);
  assign prod_en = (ENABLE40 == PHASE_PROD);

  // S carries GN_FRAC_BITS fraction; rounding half up brings it to FD_BITS.
  assign s_rnd = {1'b0, s_q} + S_HALF;
  assign s6    = s_rnd >> SH;

  // The feedback term drops the extra FD_BITS fraction of ACC*FD by truncation.
  assign sum = {{(SUM_W-S_W-1){1'b0}}, s6}
             + {{(SUM_W-ACC_W){1'b0}}, prod_q[PROD_W-1:FD_BITS]};
  assign sat = (sum > SUM_MAX);
  assign unused_prod_frac = ^prod_q[FD_BITS-1:0];

  always_comb begin
    in_r_d    = in_r_q;
    s_d       = s_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    adc_out_d = adc_out_q;
    ovf_d     = ovf_q;

    if (strobe) begin
      in_r_d    = ADC_IN;
      s_d       = {{GN_BITS{1'b0}}, in_r_q} * {{ADC_WIDTH{1'b0}}, GN};
      acc_d     = sat ? ACC_MAX : sum[ACC_W-1:0];
      adc_out_d = round_sat(acc_q);
    end

    // PROD sees the ACC written on the preceding strobe, closing the loop
    // inside one 40 MHz period.
    if (prod_en) begin
      prod_d = {{FD_BITS{1'b0}}, acc_q} * {{ACC_W{1'b0}}, FD};
    end

    // Saturation has priority over a simultaneous clear.
    if (strobe && sat) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_r_q    <= '0;
      s_q       <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      adc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_r_q    <= in_r_d;
      s_q       <= s_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      adc_out_q <= adc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ADC_OUT  = adc_out_q;
  assign OVERFLOW = ovf_q;

`ifdef COMPAT_TOTD_RECONV_DEBUG_EN
  logic [4*ADC_WIDTH-1:0] debug_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      debug_q <= '0;
    end else begin
      debug_q <= {adc_out_q,
                  acc_q[ACC_W-1:FD_BITS],
                  s6[FD_BITS +: ADC_WIDTH],
                  in_r_q};
    end
  end

  assign DEBUG = debug_q;
`endif

endmodule : reconvolve_40mhz

// File: tb/tb_reconvolve_40mhz.sv
// -----------------------------------------------------------------------------
// tb_reconvolve_40mhz
// Directed and randomized stimulus for reconvolve_40mhz. Expected outputs come
// from an arithmetic model of x[n] = round(GN*y[n]) + trunc(FD*x[n-1]) in
// 1/64 units, with a 4-strobe pipeline delay applied through expected queues.
// -----------------------------------------------------------------------------
module tb_reconvolve_40mhz;

  localparam int ACC_FULL = 262144;   // 2^(12+6)

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  ENABLE40 = 2'd1;
  logic [11:0] ADC_IN = '0;
  logic [5:0]  FD = '0;
  logic [7:0]  GN = '0;
  logic        CLR_OVF = 1'b0;
  logic [11:0] ADC_OUT;
  logic        OVERFLOW;
`ifdef COMPAT_TOTD_RECONV_DEBUG_EN
  logic [47:0] debug;
`endif

  always #4 CLK = ~CLK;

  reconvolve_40mhz dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE40 (ENABLE40),
    .ADC_IN   (ADC_IN),
    .FD       (FD),
    .GN       (GN),
    .CLR_OVF  (CLR_OVF),
    .ADC_OUT  (ADC_OUT),
`ifdef COMPAT_TOTD_RECONV_DEBUG_EN
    .DEBUG    (debug),
`endif
    .OVERFLOW (OVERFLOW)
  );

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [11:0] exp_q[$];
  logic        exp_ovf_q[$];
  logic [11:0] obs_q[$];
  int          m_acc;
  bit          m_ovf;
  int          cur_gn;
  int          cur_fd;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_out(input int acc);
    if (acc + 32 >= ACC_FULL) return 4095;
    return (acc + 32) / 64;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int gn, input int fd);
    @(negedge CLK);
    RESET = 1'b1;
    GN = 8'(gn);
    FD = 6'(fd);
    ENABLE40 = 2'd1;
    #1;
    chk("reset_adc_out", {20'd0, ADC_OUT}, 32'd0);
    chk("reset_overflow", {31'd0, OVERFLOW}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    cur_gn = gn;
    cur_fd = fd;
    m_acc = 0;
    m_ovf = 1'b0;
    exp_q = '{12'd0, 12'd0, 12'd0};
    exp_ovf_q = '{1'b0, 1'b0};
    obs_q.delete();
  endtask

  // One 40 MHz period: strobe with y, then phases 1/2 (and sometimes 3) with
  // junk on ADC_IN, which the DUT must ignore. Outputs are checked at the end,
  // so they must also have held through the non-strobe phases.
  task automatic strobe(input int y);
    int s6;
    int nxt;
    s6  = (y * cur_gn + 1) / 2;
    nxt = s6 + (m_acc * cur_fd) / 64;
    if (nxt > ACC_FULL - 1) begin
      nxt = ACC_FULL - 1;
      m_ovf = 1'b1;
    end
    m_acc = nxt;
    exp_q.push_back(12'(model_out(m_acc)));
    exp_ovf_q.push_back(m_ovf);

    @(negedge CLK);
    ENABLE40 = 2'd0;
    ADC_IN = 12'(y);
    @(negedge CLK);
    ENABLE40 = 2'd1;
    ADC_IN = 12'($urandom);
    @(negedge CLK);
    ENABLE40 = 2'd2;
    ADC_IN = 12'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      @(negedge CLK);
      ENABLE40 = 2'd3;
      ADC_IN = 12'($urandom);
    end
    chk("adc_out", {20'd0, ADC_OUT}, {20'd0, exp_q.pop_front()});
    chk("overflow", {31'd0, OVERFLOW}, {31'd0, exp_ovf_q.pop_front()});
    obs_q.push_back(ADC_OUT);
  endtask

  task automatic strobes(input int y, input int n);
    for (int i = 0; i < n; i++) strobe(y);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int decay_seq[9];
    bit mono;
    decay_seq = '{64, 32, 16, 8, 4, 2, 1, 1, 0};

    // Impulse, no decay
    do_reset(128, 0);
    strobe(100);
    strobes(0, 10);
    chk("imp_before", {20'd0, obs_q[2]}, 32'd0);
    chk("imp_peak", {20'd0, obs_q[3]}, 32'd100);
    chk("imp_after", {20'd0, obs_q[4]}, 32'd0);
    chk("imp_ovf", {31'd0, OVERFLOW}, 32'd0);

    // Impulse with 0.5 decay
    do_reset(128, 32);
    strobe(64);
    strobes(0, 11);
    for (int i = 0; i < 9; i++) chk("decay_seq", {20'd0, obs_q[3+i]}, 32'(decay_seq[i]));

    // Pedestal preservation
    do_reset(32, 48);
    strobes(50, 44);
    mono = 1'b1;
    for (int i = 1; i < obs_q.size(); i++) if (obs_q[i] < obs_q[i-1]) mono = 1'b0;
    chk("ped_monotonic", {31'd0, mono}, 32'd1);
    chk("ped_final", {31'd0, (obs_q[$] >= 12'd49 && obs_q[$] <= 12'd51)}, 32'd1);

    // Saturation, sticky flag, clear
    do_reset(255, 63);
    strobes(4095, 6);
    chk("sat_out", {20'd0, ADC_OUT}, 32'd4095);
    chk("sat_ovf", {31'd0, OVERFLOW}, 32'd1);
    strobes(0, 5);
    chk("sat_ovf_held", {31'd0, OVERFLOW}, 32'd1);
    @(negedge CLK);
    ENABLE40 = 2'd3;
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    chk("ovf_cleared", {31'd0, OVERFLOW}, 32'd0);
    m_ovf = 1'b0;
    foreach (exp_ovf_q[i]) exp_ovf_q[i] = 1'b0;
    strobes(0, 4);

    // Reset in the middle of a decay, then a clean impulse
    do_reset(128, 32);
    strobe(200);
    strobes(0, 5);
    do_reset(128, 32);
    strobe(64);
    strobes(0, 11);
    for (int i = 0; i < 9; i++) chk("post_reset_seq", {20'd0, obs_q[3+i]}, 32'(decay_seq[i]));

    // Random gain/decay/sample segments
    for (int seg = 0; seg < 8; seg++) begin
      do_reset(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 1) == 0) strobe(int'($urandom_range(0, 300)));
        else strobe(int'($urandom_range(0, 4095)));
      end
      strobes(0, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reconvolve_40mhz
